ph_alarm_monitor: RTL and testbench

Sequential stage directly downstream of the blood-pH analyzer. Consumes the per-sample `abnormalityP` (pH outside 7–8) and `abnormalityQ` (pH outside 6–9) flags and filters them over consecutive samples. Drives a four-state alarm state machine with an operator acknowledge handshake. Produces registered warning and alarm indicators plus a saturating count of alarm events for the display stage.

---
 rtl/ph_alarm_pkg.sv | 22 ++
 rtl/ph_run_counter.sv | 30 +++
 rtl/ph_alarm_monitor.sv | 123 ++++++++++++
 tb/tb_ph_alarm_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ph_alarm_pkg.sv
// ph_alarm_monitor shared types
// State encoding, counter widths, helpers
package ph_alarm_pkg;

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = 4'd15;
  localparam int EVT_W = 8;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_WARN   = 2'd1,
    ST_ALARM  = 2'd2,
    ST_ACKED  = 2'd3
  } state_e;

  function automatic logic [RUN_W-1:0] sat_inc(
    input logic [RUN_W-1:0] v
  );
    return (v == RUN_MAX) ? v : v + RUN_W'(1);
  endfunction

endpackage

// File: rtl/ph_run_counter.sv
// Saturating run-length counter
// Exposes its post-update value for threshold checks
module ph_run_counter
  import ph_alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hit,
  input  logic             clr,
  output logic [RUN_W-1:0] cnt_d
);

  logic [RUN_W-1:0] cnt_q;
  logic [RUN_W-1:0] base;

  // clear first, then apply this cycle's sample
  always_comb begin
    base  = clr ? '0 : cnt_q;
    cnt_d = base;
    if (en) cnt_d = hit ? sat_inc(base) : '0;
  end

  // run register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ph_alarm_monitor.sv
// pH alarm filter and operator-ack FSM
// Moore outputs plus saturating alarm event count
module ph_alarm_monitor
  import ph_alarm_pkg::*;
#(
  parameter int unsigned WARN_COUNT   = 3,
  parameter int unsigned SEVERE_COUNT = 2,
  parameter int unsigned CLEAR_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic             abnormality_p,
  input  logic             abnormality_q,
  input  logic             ack,
  output logic [1:0]       state,
  output logic             warn,
  output logic             alarm,
  output logic             alarm_pulse,
  output logic [EVT_W-1:0] event_count
);

  state_e state_q, state_d;
  logic pulse_q, pulse_d;
  logic blk_q, blk_d;
  logic [EVT_W-1:0] evt_q, evt_d;

  logic [RUN_W-1:0] abn_d, sev_d, nrm_d;
  logic abnormal, ack_take, entering;
  logic abn_hit, sev_hit, nrm_hit;

  assign abnormal = abnormality_p | abnormality_q;

  // a held ack acknowledges only once
  assign ack_take = ack & ~blk_q
                  & (state_q == ST_ALARM);

  ph_run_counter u_abn (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sample_valid),
    .hit   (abnormal),
    .clr   (ack_take),
    .cnt_d (abn_d)
  );

  ph_run_counter u_sev (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sample_valid),
    .hit   (abnormality_q),
    .clr   (ack_take),
    .cnt_d (sev_d)
  );

  ph_run_counter u_nrm (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sample_valid),
    .hit   (~abnormal),
    .clr   (ack_take),
    .cnt_d (nrm_d)
  );

  assign abn_hit = sample_valid
    & (abn_d == RUN_W'(WARN_COUNT));
  assign sev_hit = sample_valid
    & (sev_d == RUN_W'(SEVERE_COUNT));
  assign nrm_hit = sample_valid
    & (nrm_d == RUN_W'(CLEAR_COUNT));

  // state, pulse, ack lock and event register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      pulse_q <= 1'b0;
      blk_q   <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      blk_q   <= blk_d;
      evt_q   <= evt_d;
    end
  end

  // next state; severe beats clear
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (sev_hit)      state_d = ST_ALARM;
        else if (abn_hit) state_d = ST_WARN;
      end
      ST_WARN, ST_ACKED: begin
        if (sev_hit)      state_d = ST_ALARM;
        else if (nrm_hit) state_d = ST_NORMAL;
      end
      ST_ALARM: begin
        if (ack_take) state_d = ST_ACKED;
      end
      default: state_d = ST_NORMAL;
    endcase
    entering = (state_d == ST_ALARM)
             & (state_q != ST_ALARM);
    pulse_d = entering;
    evt_d = evt_q;
    if (entering && evt_q != '1)
      evt_d = evt_q + EVT_W'(1);
    blk_d = ack & (blk_q | ack_take);
  end

  // Moore output decode
  always_comb begin
    state       = state_q;
    warn        = (state_q == ST_WARN)
                | (state_q == ST_ACKED);
    alarm       = (state_q == ST_ALARM);
    alarm_pulse = pulse_q;
    event_count = evt_q;
  end

endmodule

// File: tb/tb_ph_alarm_monitor.sv
// ph_alarm_monitor bench: directed plan plus
// random traffic against a behavioural model
module tb_ph_alarm_monitor;

  localparam int W = 3;
  localparam int S = 2;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_valid = 1'b0;
  logic abnormality_p = 1'b0;
  logic abnormality_q = 1'b0;
  logic ack = 1'b0;
  logic [1:0] state;
  logic warn, alarm, alarm_pulse;
  logic [7:0] event_count;

  int checks = 0;
  int failures = 0;

  int m_st, m_abn, m_sev, m_nrm, m_evt;
  bit m_pulse, m_blk;

  always #5 clk = ~clk;

  ph_alarm_monitor #(
    .WARN_COUNT   (W),
    .SEVERE_COUNT (S),
    .CLEAR_COUNT  (C)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid  (sample_valid),
    .abnormality_p (abnormality_p),
    .abnormality_q (abnormality_q),
    .ack           (ack),
    .state         (state),
    .warn          (warn),
    .alarm         (alarm),
    .alarm_pulse   (alarm_pulse),
    .event_count   (event_count)
  );

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int inc15(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_abn = 0; m_sev = 0;
    m_nrm = 0; m_evt = 0;
    m_pulse = 0; m_blk = 0;
  endtask

  // one clock edge worth of the alarm rules
  task automatic model_step();
    bit took, ab;
    int ns;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ab = abnormality_p | abnormality_q;
    took = (m_st == 2) && ack && !m_blk;
    ns = m_st;
    if (took) begin
      m_abn = 0; m_sev = 0; m_nrm = 0;
      ns = 3;
    end
    if (sample_valid) begin
      m_abn = ab ? inc15(m_abn) : 0;
      m_sev = abnormality_q ? inc15(m_sev) : 0;
      m_nrm = !ab ? inc15(m_nrm) : 0;
      if (!took && m_st != 2) begin
        if (m_sev == S) ns = 2;
        else if (m_st == 0 && m_abn == W) ns = 1;
        else if (m_st != 0 && m_nrm == C) ns = 0;
      end
    end
    m_pulse = (ns == 2) && (m_st != 2);
    if (m_pulse && m_evt < 255) m_evt++;
    m_blk = ack && (m_blk || took);
    m_st = ns;
  endtask

  task automatic compare();
    check("state", int'(state), m_st);
    check("warn", int'(warn),
          int'(m_st == 1 || m_st == 3));
    check("alarm", int'(alarm), int'(m_st == 2));
    check("pulse", int'(alarm_pulse), int'(m_pulse));
    check("evt", int'(event_count), m_evt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic smp(input bit v, input bit p,
                     input bit q, input bit a);
    sample_valid = v;
    abnormality_p = p;
    abnormality_q = q;
    ack = a;
    tick();
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check("rst_state", int'(state), 0);
    check("rst_evt", int'(event_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3 P-only samples raise WARN
    smp(1, 1, 0, 0);
    smp(1, 1, 0, 0);
    check("w2_state", int'(state), 0);
    smp(1, 1, 0, 0);
    check("w3_state", int'(state), 1);
    check("w3_warn", int'(warn), 1);
    check("w3_alarm", int'(alarm), 0);

    // clear run must be consecutive
    repeat (3) smp(1, 0, 0, 0);
    check("c3_state", int'(state), 1);
    smp(1, 1, 0, 0);
    repeat (3) smp(1, 0, 0, 0);
    check("c3b_state", int'(state), 1);
    smp(1, 0, 0, 0);
    check("c4_state", int'(state), 0);

    // 2 severe samples raise ALARM
    smp(1, 1, 1, 0);
    check("s1_state", int'(state), 0);
    smp(1, 1, 1, 0);
    check("s2_state", int'(state), 2);
    check("s2_pulse", int'(alarm_pulse), 1);
    check("s2_evt", int'(event_count), 1);
    smp(0, 0, 0, 0);
    check("s3_pulse", int'(alarm_pulse), 0);

    // held ack: one ACKED, sev_run restarts at 1
    smp(1, 1, 1, 1);
    check("a1_state", int'(state), 3);
    check("a1_warn", int'(warn), 1);
    smp(1, 1, 1, 1);
    check("a2_state", int'(state), 2);
    check("a2_evt", int'(event_count), 2);
    smp(0, 0, 0, 1);
    check("a3_state", int'(state), 2);
    smp(0, 0, 0, 0);

    // ack, then clear back to NORMAL
    smp(1, 0, 0, 1);
    check("k1_state", int'(state), 3);
    repeat (3) smp(1, 0, 0, 0);
    check("k4_state", int'(state), 0);

    // sparse samples, idle flags ignored
    for (int k = 1; k <= 3; k++) begin
      repeat (4) smp(0, 1, 1, 0);
      smp(1, 1, 0, 0);
      if (k == 2) check("sp2_state", int'(state), 0);
    end
    check("sp3_state", int'(state), 1);
    repeat (4) smp(1, 0, 0, 0);

    // walk event_count to 7, ending in ALARM
    for (int i = 0; i < 5; i++) begin
      smp(1, 0, 1, 0);
      smp(1, 0, 1, 0);
      if (i < 4) begin
        smp(0, 0, 0, 1);
        smp(0, 0, 0, 0);
      end
    end
    check("e7_evt", int'(event_count), 7);
    check("e7_state", int'(state), 2);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("ar_state", int'(state), 0);
    check("ar_alarm", int'(alarm), 0);
    check("ar_warn", int'(warn), 0);
    check("ar_pulse", int'(alarm_pulse), 0);
    check("ar_evt", int'(event_count), 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      sample_valid = ($urandom_range(3) != 0);
      abnormality_p = $urandom_range(1);
      abnormality_q = ($urandom_range(3) == 0);
      ack = ($urandom_range(5) == 0);
      if ($urandom_range(999) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
